jtag_dr_bank: RTL and testbench

- Data-register bank and TDO output stage, directly downstream of the TAP controller and instruction register.
- Decodes the latched 4-bit JTAG_IR to pick one of three registers: BYPASS, IDCODE or USER scan register.
- Captures, shifts and updates the selected register from the TAP state.
- Drives TDO and TDO_OE, retimed on the falling edge of TCK per IEEE 1149.1.

---
 rtl/jtag_pkg.sv | 51 +++++
 rtl/jtag_shift_reg.sv | 39 +++
 rtl/jtag_dr_bank.sv | 175 +++++++++++++++++
 tb/tb_jtag_dr_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared constants for the JTAG data-register bank.
//   - TAP state encodings (as presented on the 'state' bus by the TAP FSM)
//   - instruction opcodes
//   - data-register select type and the IR decode helper
// Optional feature macro: JTAG_USERCODE_EN (adds the USERCODE opcode decode).
package jtag_pkg;

  // TAP controller states
  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SHF_DR = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SHF_IR = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  // Instruction opcodes
  localparam logic [3:0] IR_IDCODE   = 4'h1;
  localparam logic [3:0] IR_USER     = 4'h2;
  localparam logic [3:0] IR_USERCODE = 4'h8;
  localparam logic [3:0] IR_BYPASS   = 4'hF;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER,
    DR_USERCODE
  } dr_sel_e;

  // Unknown opcodes fall back to BYPASS so the chain length stays defined.
  function automatic dr_sel_e decode_ir(input logic [3:0] ir);
    case (ir)
      IR_IDCODE:   return DR_IDCODE;
      IR_USER:     return DR_USER;
`ifdef JTAG_USERCODE_EN
      IR_USERCODE: return DR_USERCODE;
`endif
      default:     return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: generic capture/shift data register.
//   tck     in  rising-edge clock
//   trst_n  in  async active-low clear
//   clr     in  synchronous clear (Test-Logic-Reset)
//   cap_en  in  load cap_val
//   shf_en  in  shift right, si enters MSB
//   si      in  serial in
//   cap_val in  [W] capture value
//   q       out [W] register contents; q[0] is the serial-out bit
module jtag_shift_reg #(
  parameter int W = 32
) (
  input  logic         tck,
  input  logic         trst_n,
  input  logic         clr,
  input  logic         cap_en,
  input  logic         shf_en,
  input  logic         si,
  input  logic [W-1:0] cap_val,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr)         sr_d = '0;
    else if (cap_en) sr_d = cap_val;
    else if (shf_en) sr_d = {si, sr_q[W-1:1]};
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  assign q = sr_q;

endmodule

// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: JTAG data-register bank (BYPASS / IDCODE / USER) and TDO stage.
//   TCK      in  JTAG clock
//   TRST     in  async active-low reset
//   TDI      in  serial data in
//   state    in  [4] TAP state (jtag_pkg encodings)
//   JTAG_IR  in  [4] current instruction
//   ir_so    in  IR serial out, forwarded in Shift-IR
//   USER_IN  in  [USER_W] USER capture value
//   USER_OUT out [USER_W] USER update latch
//   TDO      out serial out, retimed on falling TCK, 0 when idle
//   TDO_OE   out high while TDO carries shift data
// Optional feature macro: JTAG_USERCODE_EN (32-bit USERCODE register on IR 4'h8).
module jtag_dr_bank
  import jtag_pkg::*;
#(
  parameter logic [31:0]       IDCODE_VAL   = 32'h1000_0001,
  parameter int                USER_W       = 8,
  parameter logic [USER_W-1:0] USER_RST     = '0,
  parameter logic [31:0]       USERCODE_VAL = 32'h0000_0000
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              TDI,
  input  logic [3:0]        state,
  input  logic [3:0]        JTAG_IR,
  input  logic              ir_so,
  input  logic [USER_W-1:0] USER_IN,
  output logic [USER_W-1:0] USER_OUT,
  output logic              TDO,
  output logic              TDO_OE
);

  dr_sel_e sel;
  logic    in_tlr, in_cap, in_shf;

  // IR is stable across a DR scan, so a combinational decode is enough;
  // a new IR naturally takes effect at the next Capture-DR.
  assign sel    = decode_ir(JTAG_IR);
  assign in_tlr = (state == TLR);
  assign in_cap = (state == CAP_DR);
  assign in_shf = (state == SHF_DR);

  // ---------------- BYPASS: single stage ----------------
  logic bypass_q, bypass_d;

  always_comb begin
    bypass_d = bypass_q;
    if (in_tlr) bypass_d = 1'b0;
    else if (sel == DR_BYPASS) begin
      if (in_cap)      bypass_d = 1'b0;
      else if (in_shf) bypass_d = TDI;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) bypass_q <= 1'b0;
    else       bypass_q <= bypass_d;
  end

  // ---------------- IDCODE ----------------
  logic [31:0] idcode_q;
  logic        unused_idcode_hi;

  jtag_shift_reg #(.W(32)) u_idcode (
    .tck     (TCK),
    .trst_n  (TRST),
    .clr     (in_tlr),
    .cap_en  (in_cap && sel == DR_IDCODE),
    .shf_en  (in_shf && sel == DR_IDCODE),
    .si      (TDI),
    .cap_val (IDCODE_VAL),
    .q       (idcode_q)
  );

  // Only the serial-out bit of IDCODE is observed.
  assign unused_idcode_hi = ^idcode_q[31:1];

  // ---------------- USER ----------------
  logic [USER_W-1:0] user_q;

  jtag_shift_reg #(.W(USER_W)) u_user (
    .tck     (TCK),
    .trst_n  (TRST),
    .clr     (in_tlr),
    .cap_en  (in_cap && sel == DR_USER),
    .shf_en  (in_shf && sel == DR_USER),
    .si      (TDI),
    .cap_val (USER_IN),
    .q       (user_q)
  );

  logic [USER_W-1:0] user_out_q, user_out_d;

  always_comb begin
    user_out_d = user_out_q;
    if (in_tlr)                                  user_out_d = USER_RST;
    else if (state == UPD_DR && sel == DR_USER) user_out_d = user_q;
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) user_out_q <= USER_RST;
    else       user_out_q <= user_out_d;
  end

  assign USER_OUT = user_out_q;

  // ---------------- USERCODE (optional) ----------------
  logic usercode_so;

`ifdef JTAG_USERCODE_EN
  logic [31:0] usercode_q;
  logic        unused_usercode_hi;

  jtag_shift_reg #(.W(32)) u_usercode (
    .tck     (TCK),
    .trst_n  (TRST),
    .clr     (in_tlr),
    .cap_en  (in_cap && sel == DR_USERCODE),
    .shf_en  (in_shf && sel == DR_USERCODE),
    .si      (TDI),
    .cap_val (USERCODE_VAL),
    .q       (usercode_q)
  );

  assign usercode_so        = usercode_q[0];
  assign unused_usercode_hi = ^usercode_q[31:1];
`else
  logic unused_usercode_val;

  assign usercode_so         = 1'b0;
  assign unused_usercode_val = ^USERCODE_VAL;
`endif

  // ---------------- serial-out mux ----------------
  logic dr_so;

  always_comb begin
    dr_so = bypass_q;
    case (sel)
      DR_IDCODE:   dr_so = idcode_q[0];
      DR_USER:     dr_so = user_q[0];
      DR_USERCODE: dr_so = usercode_so;
      default:     dr_so = bypass_q;
    endcase
  end

  // ---------------- falling-edge TDO stage ----------------
  logic tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;

  always_comb begin
    tdo_d    = 1'b0;
    tdo_oe_d = 1'b0;
    if (state == SHF_DR) begin
      tdo_d    = dr_so;
      tdo_oe_d = 1'b1;
    end else if (state == SHF_IR) begin
      tdo_d    = ir_so;
      tdo_oe_d = 1'b1;
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign TDO    = tdo_q;
  assign TDO_OE = tdo_oe_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// tb_jtag_dr_bank: directed bench for jtag_dr_bank.
// The TAP state is driven 1ns after each rising TCK (as a TAP FSM would),
// and outputs are sampled 1ns after the following falling TCK.
module tb_jtag_dr_bank;
  import jtag_pkg::*;

`ifdef JTAG_USERCODE_EN
  localparam logic [31:0] UCV = 32'hCAFE_F00D;
`else
  localparam logic [31:0] UCV = 32'h0000_0000;
`endif

  logic       TCK, TRST, TDI, ir_so;
  logic [3:0] state, JTAG_IR;
  logic [7:0] USER_IN, USER_OUT;
  logic       TDO, TDO_OE;

  int checks   = 0;
  int failures = 0;

  jtag_dr_bank #(.USERCODE_VAL(UCV)) dut (
    .TCK      (TCK),
    .TRST     (TRST),
    .TDI      (TDI),
    .state    (state),
    .JTAG_IR  (JTAG_IR),
    .ir_so    (ir_so),
    .USER_IN  (USER_IN),
    .USER_OUT (USER_OUT),
    .TDO      (TDO),
    .TDO_OE   (TDO_OE)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a new TAP state after the rising edge; return after the falling edge.
  task automatic goto(input logic [3:0] st, input logic tdi);
    @(posedge TCK);
    #1;
    state = st;
    TDI   = tdi;
    @(negedge TCK);
    #1;
  endtask

  // Full DR scan: Select, Capture, n x Shift, Exit1, Update, Run-Test/Idle.
  task automatic scan(input logic [3:0] ir, input int n, input logic [63:0] din,
                      input logic [63:0] dout, input logic [7:0] uo_pre, input string tag);
    JTAG_IR = ir;
    goto(SEL_DR, 1'b0);
    goto(CAP_DR, 1'b0);
    chk({tag, "_cap_oe"}, TDO_OE, 1'b0);
    for (int i = 0; i < n; i++) begin
      goto(SHF_DR, din[i]);
      chk($sformatf("%s_tdo%0d", tag, i), TDO, dout[i]);
      chk($sformatf("%s_oe%0d", tag, i), TDO_OE, 1'b1);
    end
    goto(EX1_DR, 1'b0);
    chk({tag, "_ex1_oe"}, TDO_OE, 1'b0);
    chk({tag, "_ex1_tdo"}, TDO, 1'b0);
    goto(UPD_DR, 1'b0);
    chk({tag, "_uo_pre_upd"}, USER_OUT, uo_pre);
    goto(RTI, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    TRST = 1'b0; TDI = 1'b0; ir_so = 1'b0;
    state = TLR; JTAG_IR = IR_BYPASS; USER_IN = 8'h00;

    // Reset state
    #3;
    chk("rst_uo", USER_OUT, 8'h00);
    chk("rst_tdo", TDO, 1'b0);
    chk("rst_oe", TDO_OE, 1'b0);
    #4 TRST = 1'b1;
    goto(TLR, 1'b0);
    goto(RTI, 1'b0);

    // IDCODE stream LSB-first
    scan(IR_IDCODE, 32, 64'h0, 64'h1000_0001, 8'h00, "idcode");
    chk("idcode_uo", USER_OUT, 8'h00);

    // BYPASS: TDI bits 1,0,1,1,0 -> TDO 0,1,0,1,1
    scan(IR_BYPASS, 5, 64'b01101, 64'b11010, 8'h00, "byp_f");
    scan(4'h5,      5, 64'b01101, 64'b11010, 8'h00, "byp_5");

`ifdef JTAG_USERCODE_EN
    scan(IR_USERCODE, 32, 64'h0, 64'hCAFE_F00D, 8'h00, "usercode");
`else
    scan(IR_USERCODE, 5, 64'b01101, 64'b11010, 8'h00, "byp_8");
`endif

    // USER: capture A5, shift in 3C, update only on UPD_DR edge
    USER_IN = 8'hA5;
    scan(IR_USER, 8, 64'h3C, 64'hA5, 8'h00, "user");
    chk("user_uo_post", USER_OUT, 8'h3C);

    // USER with Pause-DR: capture F0, shift in 96 in two halves
    USER_IN = 8'hF0;
    JTAG_IR = IR_USER;
    goto(SEL_DR, 1'b0);
    goto(CAP_DR, 1'b0);
    goto(SHF_DR, 1'b0); chk("pause_tdo0", TDO, 1'b0);
    goto(SHF_DR, 1'b1); chk("pause_tdo1", TDO, 1'b0);
    goto(SHF_DR, 1'b1); chk("pause_tdo2", TDO, 1'b0);
    goto(SHF_DR, 1'b0); chk("pause_tdo3", TDO, 1'b0);
    goto(EX1_DR, 1'b0);
    for (int i = 0; i < 10; i++) begin
      goto(PAU_DR, 1'b1);
      chk($sformatf("pause_oe%0d", i), TDO_OE, 1'b0);
    end
    chk("pause_tdo", TDO, 1'b0);
    goto(EX2_DR, 1'b0);
    goto(SHF_DR, 1'b1); chk("resume_tdo4", TDO, 1'b1);
    goto(SHF_DR, 1'b0); chk("resume_tdo5", TDO, 1'b1);
    goto(SHF_DR, 1'b0); chk("resume_tdo6", TDO, 1'b1);
    goto(SHF_DR, 1'b1); chk("resume_tdo7", TDO, 1'b1);
    goto(EX1_DR, 1'b0);
    goto(UPD_DR, 1'b0);
    chk("pause_uo_pre", USER_OUT, 8'h3C);
    goto(RTI, 1'b0);
    chk("pause_uo_post", USER_OUT, 8'h96);

    // Shift-IR forwards ir_so
    goto(SEL_DR, 1'b0);
    goto(SEL_IR, 1'b0);
    goto(CAP_IR, 1'b0);
    ir_so = 1'b1;
    goto(SHF_IR, 1'b0);
    chk("shir_tdo1", TDO, 1'b1);
    chk("shir_oe1", TDO_OE, 1'b1);
    ir_so = 1'b0;
    goto(SHF_IR, 1'b0);
    chk("shir_tdo0", TDO, 1'b0);
    chk("shir_oe0", TDO_OE, 1'b1);
    ir_so = 1'b1;
    goto(EX1_IR, 1'b0);
    chk("shir_ex1_oe", TDO_OE, 1'b0);
    chk("shir_ex1_tdo", TDO, 1'b0);
    goto(UPD_IR, 1'b0);
    goto(RTI, 1'b0);

    // Test-Logic-Reset reloads USER_OUT
    chk("tlr_uo_pre", USER_OUT, 8'h96);
    goto(TLR, 1'b0);
    goto(RTI, 1'b0);
    chk("tlr_uo", USER_OUT, 8'h00);

    // TRST mid-Shift-DR
    USER_IN = 8'hA5;
    scan(IR_USER, 8, 64'h3C, 64'hA5, 8'h00, "user2");
    chk("user2_uo", USER_OUT, 8'h3C);
    goto(SEL_DR, 1'b0);
    goto(CAP_DR, 1'b0);
    goto(SHF_DR, 1'b1);
    goto(SHF_DR, 1'b1);
    chk("trst_pre_oe", TDO_OE, 1'b1);
    #2 TRST = 1'b0;
    #1;
    chk("trst_uo", USER_OUT, 8'h00);
    chk("trst_tdo", TDO, 1'b0);
    chk("trst_oe", TDO_OE, 1'b0);
    #3 TRST = 1'b1;
    goto(RTI, 1'b0);
    USER_IN = 8'h5A;
    scan(IR_USER, 8, 64'hC3, 64'h5A, 8'h00, "post_trst");
    chk("post_trst_uo", USER_OUT, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
